sobel_window_loader: RTL
========================

Name: sobel_window_loader

Overview:
- Fetches pixels from image memory and maintains the 3x3 neighbourhood consumed by the horizontal/vertical gradient stages.
- Sits directly downstream of the controller: executes its initial-load and shift commands and reports per-pixel and per-batch completion back to it.
- Walks the window centre across the image in raster order (left to right, top to bottom), interior pixels only.

Parameters:
- IMG_WIDTH, 640, image width in pixels (>=3)
- IMG_HEIGHT, 480, image height in pixels (>=3)
- ADDR_W, 20, memory address width
- PIX_W, 8, pixel width

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  synchronous, active-high reset (1 = reset), sampled on rising clk
- base_addr  in  ADDR_W  address of pixel (0,0); sampled on accepted start_i_read
- start_i_read  in  1  pulse: restart at centre (1,1) and load all 9 pixels
- start_shift  in  1  pulse: advance the centre one position and load the new pixels
- mem_addr  out  ADDR_W  read address
- mem_ren  out  1  read request, one-cycle pulse
- mem_rdata  in  PIX_W  read data, valid when mem_rvalid=1
- mem_rvalid  in  1  read data valid
- window  out  9*PIX_W  p0..p8 row-major; p0 = bits [PIX_W-1:0] = top-left, p8 = bottom-right
- center_row  out  16  current centre row
- center_col  out  16  current centre column
- read_data_done  out  1  one-cycle pulse per pixel captured
- read_done  out  1  one-cycle pulse when the batch completes and window is updated
- busy  out  1  high from command acceptance until read_done
- all_done  out  1  level: image fully traversed

Behaviour:
- Reset values:
  - window = 0, mem_addr = 0, mem_ren = 0, read_data_done = 0, read_done = 0, busy = 0, all_done = 0
  - center_row = 1, center_col = 1
  - state = IDLE
- States: IDLE, ISSUE, WAIT, DONE.
- Address rule: mem_addr = base_q + r*IMG_WIDTH + c, truncated to ADDR_W.
- Command acceptance:
  - Commands are accepted only in IDLE; commands while busy = 1 are ignored.
  - If start_i_read and start_shift arrive in the same cycle, start_i_read wins.
- start_i_read:
  - latch base_q; centre = (1,1); clear all_done
  - batch = 9 reads, rows r-1..r+1, each row cols c-1..c+1
- start_shift, with all_done = 0:
  - If center_col < IMG_WIDTH-2: centre col +1.
    - Shift every window row left one position.
    - Batch = 3 reads of column c+1 (new centre), rows r-1..r+1, written to p2/p5/p8.
  - Else, if center_row < IMG_HEIGHT-2: centre = (row+1, 1); batch = full 9-pixel reload.
  - Else (last position): set all_done = 1; no reads, no busy, no read_done.
- start_shift while all_done = 1 is ignored.
- Centre registers update on the cycle after acceptance.
- Per pixel:
  - ISSUE drives mem_ren = 1 for exactly one cycle with mem_addr, then goes to WAIT.
  - WAIT holds mem_addr and waits (unbounded) for mem_rvalid.
  - On mem_rvalid: capture mem_rdata into the target window slot and pulse read_data_done the following cycle.
  - Then go to ISSUE for the next pixel, or to DONE after the last pixel.
  - There is at most one outstanding request.
- DONE: pulse read_done (coincident with the last read_data_done), drop busy, return to IDLE.
- Latency, with mem_rvalid one cycle after mem_ren:
  - command to first mem_ren = 1 cycle
  - 2 cycles per pixel
  - read_done 19 cycles after acceptance for 9 pixels, 7 cycles for 3
- mem_rvalid outside WAIT is ignored.
- Window slots not targeted by the batch hold their value during the batch. Slots are written as pixels arrive; the gradient stages must sample window only after read_done.
- Reset mid-batch: all state returns to reset values on that edge, and any late mem_rvalid afterwards is ignored.

Test Plan:
- Setup: IMG_WIDTH = 4, IMG_HEIGHT = 4, base_addr = 0x100; memory returns the low 8 bits of the address one cycle after mem_ren.
- Initial load: start_i_read -> mem_addr sequence 0x100,101,102,104,105,106,108,109,10A.
  - 9 read_data_done pulses, one read_done, busy low afterwards.
  - window p0..p8 = 00,01,02,04,05,06,08,09,0A; centre (1,1).
- Shift: start_shift -> reads 0x103,0x107,0x10B.
  - window = 01,02,03,05,06,07,09,0A,0B; centre (1,2); read_done 7 cycles after acceptance.
- Row wrap: start_shift at centre (1,2) -> centre (2,1); 9 reads from 0x104; window = 04,05,06,08,09,0A,0C,0D,0E.
- End of image: shift to (2,2) (reads 0x107,0x10B,0x10F), then start_shift again.
  - all_done = 1; no mem_ren, no read_done.
  - A later start_shift is ignored; start_i_read clears all_done and reloads (1,1).
- Busy/priority:
  - start_shift during a batch is ignored (sequence unchanged).
  - start_i_read and start_shift in the same cycle -> 9-read initial load.
  - mem_rvalid held off 5 cycles -> mem_addr stable, no extra mem_ren.
- Reset mid-batch: n_rst = 1 after the 4th pixel.
  - Next cycle all outputs are at reset values, centre (1,1).
  - A stray mem_rvalid does not change window.
  - start_i_read afterwards performs a clean 9-read load.

Source files
------------

// File: rtl/sobel_window_loader_if.sv
// Command, memory and window bundle between the controller, image memory and the 3x3 window loader.
// Latency: none, wires only.
// Backpressure: none here; the loader's busy flag and the mem_rvalid handshake carry all flow control.
// Ports: base_addr/start_i_read/start_shift (commands), mem_* (single-outstanding read port),
//        window/center_row/center_col (neighbourhood state), read_data_done/read_done/busy/all_done (status).
interface sobel_window_loader_if #(
    parameter int ADDR_W = 20,
    parameter int PIX_W  = 8
);
    logic [ADDR_W-1:0]  base_addr;
    logic               start_i_read;
    logic               start_shift;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ren;
    logic [PIX_W-1:0]   mem_rdata;
    logic               mem_rvalid;
    logic [9*PIX_W-1:0] window;
    logic [15:0]        center_row;
    logic [15:0]        center_col;
    logic               read_data_done;
    logic               read_done;
    logic               busy;
    logic               all_done;

    // Loader side.
    modport slave (
        input  base_addr, start_i_read, start_shift, mem_rdata, mem_rvalid,
        output mem_addr, mem_ren, window, center_row, center_col,
               read_data_done, read_done, busy, all_done
    );

    // Controller / memory side.
    modport master (
        output base_addr, start_i_read, start_shift, mem_rdata, mem_rvalid,
        input  mem_addr, mem_ren, window, center_row, center_col,
               read_data_done, read_done, busy, all_done
    );
endinterface

// File: rtl/sobel_window_loader.sv
// Loads and slides the 3x3 pixel neighbourhood across the image interior in raster order.
// Latency: first mem_ren 1 cycle after a command, 2 cycles per pixel; read_done 19 cycles (9 px) / 7 cycles (3 px).
// Backpressure: one outstanding read, waits indefinitely on mem_rvalid; commands are dropped while busy.
// Ports: clk, n_rst (sync active-high reset), bus (slave side of sobel_window_loader_if).
module sobel_window_loader #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int ADDR_W     = 20,
    parameter int PIX_W      = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    sobel_window_loader_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [ADDR_W-1:0]      base_q;
    logic [15:0]            ctr_row;
    logic [15:0]            ctr_col;
    logic [15:0]            pix_row;      // image coordinates of the pixel being fetched
    logic [15:0]            pix_col;
    logic [3:0]             cnt;          // pixel index within the current batch
    logic                   col_batch;    // 1: 3-pixel right-column batch, 0: full 9-pixel load
    logic                   done_q;
    logic                   rdd_q;
    logic [8:0][PIX_W-1:0]  win;

    logic                   cmd_init;
    logic                   cmd_col;
    logic                   cmd_row;
    logic                   cmd_end;
    logic                   capture;
    logic                   last_pix;
    logic [3:0]             slot;

    always_ff @(posedge clk) begin
        if (n_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_init  = 1'b0;
        cmd_col   = 1'b0;
        cmd_row   = 1'b0;
        cmd_end   = 1'b0;
        capture   = 1'b0;
        last_pix  = col_batch ? (cnt == 4'd2) : (cnt == 4'd8);
        // Column batches land in the right-hand column p2/p5/p8.
        slot      = col_batch ? (cnt + cnt + cnt + 4'd2) : cnt;
        case (state)
            IDLE: begin
                if (bus.start_i_read) begin
                    cmd_init  = 1'b1;
                    state_nxt = ISSUE;
                end else if (bus.start_shift && !done_q) begin
                    if (ctr_col < 16'(IMG_WIDTH - 2)) begin
                        cmd_col   = 1'b1;
                        state_nxt = ISSUE;
                    end else if (ctr_row < 16'(IMG_HEIGHT - 2)) begin
                        cmd_row   = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        // Last interior position already loaded: flag completion, no batch.
                        cmd_end   = 1'b1;
                    end
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (bus.mem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = last_pix ? DONE : ISSUE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            base_q    <= '0;
            ctr_row   <= 16'd1;
            ctr_col   <= 16'd1;
            pix_row   <= '0;
            pix_col   <= '0;
            cnt       <= '0;
            col_batch <= 1'b0;
            done_q    <= 1'b0;
            rdd_q     <= 1'b0;
            win       <= '0;
        end else begin
            rdd_q <= capture;
            if (cmd_init) begin
                base_q    <= bus.base_addr;
                ctr_row   <= 16'd1;
                ctr_col   <= 16'd1;
                done_q    <= 1'b0;
                pix_row   <= '0;
                pix_col   <= '0;
                cnt       <= '0;
                col_batch <= 1'b0;
            end else if (cmd_col) begin
                ctr_col   <= ctr_col + 16'd1;
                pix_row   <= ctr_row - 16'd1;
                pix_col   <= ctr_col + 16'd2;
                cnt       <= '0;
                col_batch <= 1'b1;
                // Slide each row left; p2/p5/p8 keep their value until refetched.
                win[0]    <= win[1];
                win[1]    <= win[2];
                win[3]    <= win[4];
                win[4]    <= win[5];
                win[6]    <= win[7];
                win[7]    <= win[8];
            end else if (cmd_row) begin
                ctr_row   <= ctr_row + 16'd1;
                ctr_col   <= 16'd1;
                pix_row   <= ctr_row;         // new centre row minus one
                pix_col   <= '0;
                cnt       <= '0;
                col_batch <= 1'b0;
            end else if (cmd_end) begin
                done_q    <= 1'b1;
            end

            if (capture) begin
                win[slot] <= bus.mem_rdata;
                cnt       <= cnt + 4'd1;
                // Keep the last address on the bus once the batch is complete.
                if (!last_pix) begin
                    if (col_batch) begin
                        pix_row <= pix_row + 16'd1;
                    end else if (pix_col == ctr_col + 16'd1) begin
                        pix_col <= ctr_col - 16'd1;
                        pix_row <= pix_row + 16'd1;
                    end else begin
                        pix_col <= pix_col + 16'd1;
                    end
                end
            end
        end
    end

    assign bus.mem_addr       = base_q + ADDR_W'(pix_row) * ADDR_W'(IMG_WIDTH) + ADDR_W'(pix_col);
    assign bus.mem_ren        = (state == ISSUE);
    assign bus.read_done      = (state == DONE);
    assign bus.busy           = (state != IDLE);
    assign bus.read_data_done = rdd_q;
    assign bus.all_done       = done_q;
    assign bus.window         = win;
    assign bus.center_row     = ctr_row;
    assign bus.center_col     = ctr_col;

endmodule
